// File: rtl/prog_loader.sv
// Program-load stage: assembles little-endian 32-bit words from a byte stream,
// writes them into the core's memory load port, then pulses the core's start.
module prog_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W:0]   nwords,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              memwe,
  output logic [31:0]       memin,
  output logic [ADDR_W-1:0] memaddr,
  output logic              start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    START = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          bsel_q, bsel_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         memin_q, memin_d;
  logic [ADDR_W-1:0]   memaddr_q, memaddr_d;
  logic                done_q, done_d;
  logic                last_word;

  assign last_word  = ({1'b0, idx_q} == (cnt_q - ONE_W));
  assign byte_ready = (state_q == RECV);
  assign memwe      = (state_q == WRITE);
  assign start      = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign memin      = memin_q;
  assign memaddr    = memaddr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bsel_d    = bsel_q;
    word_d    = word_q;
    memin_d   = memin_q;
    memaddr_d = memaddr_q;
    done_d    = done_q;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          // Zero and anything beyond the memory depth both mean "fill it all".
          cnt_d   = ((nwords == '0) || (nwords > DEPTH)) ? DEPTH : nwords;
          idx_d   = '0;
          bsel_d  = '0;
          done_d  = 1'b0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (byte_valid && byte_ready) begin
          word_d[8*bsel_q +: 8] = byte_data;
          bsel_d                = bsel_q + 2'd1;
          if (bsel_q == 2'd3) begin
            // Load the output registers now so they are valid during WRITE.
            memin_d   = word_d;
            memaddr_d = idx_q;
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d = START;
        end else begin
          idx_d   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = RECV;
        end
      end
      START: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      bsel_q    <= '0;
      word_q    <= '0;
      memin_q   <= '0;
      memaddr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bsel_q    <= bsel_d;
      word_q    <= word_d;
      memin_q   <= memin_d;
      memaddr_q <= memaddr_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: byte streams with gaps, compared against a
// memory image computed directly from the byte sequence.
module tb_prog_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic [ADDR_W:0]   nwords;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              memwe;
  logic [31:0]       memin;
  logic [ADDR_W-1:0] memaddr;
  logic              start;
  logic              busy;
  logic              done;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .nwords     (nwords),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .memwe      (memwe),
    .memin      (memin),
    .memaddr    (memaddr),
    .start      (start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed write/start traffic
  int   wa_q[$];
  int   wd_q[$];
  int   start_cnt;
  int   start_cyc;
  int   last_we_cyc;
  int   overlap_cnt;

  logic [7:0] bytes_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (memwe) begin
      wa_q.push_back(int'(memaddr));
      wd_q.push_back(int'(memin));
      last_we_cyc = cyc;
    end
    if (start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
    if (start && memwe) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_monitor();
    wa_q.delete();
    wd_q.delete();
    start_cnt   = 0;
    start_cyc   = -1;
    last_we_cyc = -1;
    overlap_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends bytes_q[first .. first+count-1]; optionally pokes load_req mid-stream.
  task automatic send_bytes(input int first, input int count, input int gapmax, input bit poke);
    bit accepted;
    int waited;
    for (int i = first; i < first + count; i++) begin
      if (poke && i == first + 5) begin
        byte_valid = 1'b0;
        load_req   = 1'b1;
        nwords     = 6'd1;
        step();
        load_req   = 1'b0;
      end
      repeat ($urandom_range(0, gapmax)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        step();
      end
      byte_valid = 1'b1;
      byte_data  = bytes_q[i];
      accepted   = 1'b0;
      waited     = 0;
      while (!accepted && waited < 100) begin
        @(negedge clk);
        accepted = byte_ready;
        step();
        waited++;
      end
      if (!accepted) begin
        check("byte_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        return;
      end
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  // pattern: 0 ramp, 1 random, 2 the fixed 78 56 34 12 word
  task automatic run_session(input logic [ADDR_W:0] nw, input int gapmax, input int pattern, input bit poke);
    int n, k;
    bit got;
    logic [31:0] exp_word;
    logic [7:0] fixed_b [4];
    fixed_b[0] = 8'h78; fixed_b[1] = 8'h56; fixed_b[2] = 8'h34; fixed_b[3] = 8'h12;
    n = (nw == 0 || int'(nw) > DEPTH) ? DEPTH : int'(nw);
    bytes_q.delete();
    for (int i = 0; i < 4 * n; i++) begin
      case (pattern)
        0:       bytes_q.push_back(8'(i));
        1:       bytes_q.push_back(8'($urandom));
        default: bytes_q.push_back(fixed_b[i % 4]);
      endcase
    end
    clear_monitor();
    load_req = 1'b1;
    nwords   = nw;
    step();
    load_req = 1'b0;
    nwords   = 6'($urandom);
    k        = cyc;
    check("ready_after_req", 32'(byte_ready), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    send_bytes(0, 4 * n, gapmax, poke);

    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (start) got = 1'b1;
      else step();
    end
    check("start_seen", 32'(got), 32'd1);
    if (got) begin
      if (poke) begin
        load_req = 1'b1;
        nwords   = 6'd1;
      end
      step();
      load_req = 1'b0;
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd1);
    check("idle_ready", 32'(byte_ready), 32'd0);
    repeat (3) step();

    check("n_writes", 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      exp_word = {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]};
      check("w_addr", 32'(wa_q[i]), 32'(i));
      check("w_data", 32'(wd_q[i]), exp_word);
    end
    check("start_count", 32'(start_cnt), 32'd1);
    check("start_after_last_we", 32'(start_cyc), 32'(last_we_cyc + 1));
    check("start_we_overlap", 32'(overlap_cnt), 32'd0);
    if (gapmax == 0 && !poke)
      check("session_latency", 32'(start_cyc - k), 32'(5 * n));
    $display("session nwords=%0d eff=%0d gapmax=%0d poke=%0d writes=%0d starts=%0d",
             nw, n, gapmax, poke, wa_q.size(), start_cnt);
  endtask

  initial begin
    rst        = 1'b1;
    load_req   = 1'b0;
    nwords     = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    clear_monitor();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_memwe", 32'(memwe), 32'd0);
    check("rst_memin", memin, 32'd0);
    check("rst_memaddr", 32'(memaddr), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      byte_valid = i[0];
      byte_data  = 8'($urandom);
      step();
    end
    byte_valid = 1'b0;
    check("idle_no_memwe", 32'(wa_q.size()), 32'd0);
    check("idle_no_start", 32'(start_cnt), 32'd0);
    $display("reset test done");

    run_session(6'd1, 0, 2, 1'b0);
    run_session(6'd0, 0, 0, 1'b0);
    run_session(6'd40, 5, 0, 1'b1);
    for (int s = 0; s < 4; s++)
      run_session(6'($urandom_range(0, 63)), 2, 1, s[0]);

    // Abort a 4-word session after 9 bytes.
    bytes_q.delete();
    for (int i = 0; i < 16; i++) bytes_q.push_back(8'($urandom));
    clear_monitor();
    load_req = 1'b1;
    nwords   = 6'd4;
    step();
    load_req = 1'b0;
    send_bytes(0, 9, 0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("abort_writes", 32'(wa_q.size()), 32'd2);
    for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
      check("abort_w_addr", 32'(wa_q[i]), 32'(i));
      check("abort_w_data", 32'(wd_q[i]),
            {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]});
    end
    check("abort_start", 32'(start_cnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    $display("abort session writes=%0d starts=%0d done=%0d", wa_q.size(), start_cnt, done);
    step();
    run_session(6'd1, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
